// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for an asymmetric-width FWFT FIFO memory.
// Occupancy is tracked in memory-word units; pushes and pops advance by their own step.
module fifo_ctrl #(
    parameter int unsigned W_DATA_WIDTH = 16,
    parameter int unsigned R_DATA_WIDTH = 64,
    parameter int unsigned MEM_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  err_ovf,
    output logic                  err_udf
);

    localparam int unsigned WR_STEP = W_DATA_WIDTH / MEM_WIDTH;
    localparam int unsigned RD_STEP = R_DATA_WIDTH / MEM_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [CNT_W-1:0]      count_nxt;

    // Flags come from the pre-edge count, so boundary push/pop pairs resolve on old state
    assign full  = (count > CNT_W'(FIFO_DEPTH - WR_STEP));
    assign empty = (count < CNT_W'(RD_STEP));

    // rst_n gating keeps the memory from being written while reset is asserted
    assign push_ok = push & ~full & rst_n & ~flush;
    assign pop_ok  = pop & ~empty & rst_n & ~flush;

    assign wr_en   = push_ok;
    assign wr_addr = wr_ptr;
    assign rd_en   = ~empty;
    assign rd_addr = rd_ptr;

    always_comb begin
        count_nxt = count;
        if (push_ok) count_nxt = count_nxt + CNT_W'(WR_STEP);
        if (pop_ok)  count_nxt = count_nxt - CNT_W'(RD_STEP);
    end

    // Pointers wrap naturally at FIFO_DEPTH since it equals 2**ADDR_WIDTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(WR_STEP);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(RD_STEP);
            count <= count_nxt;
            if (push && full)  err_ovf <= 1'b1;
            if (pop  && empty) err_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at default parameters (1-word push, 4-word pop, 16 words).
module tb_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic       flush;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       err_ovf;
    logic       err_udf;

    int total = 0;
    int bad   = 0;

    fifo_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled 1 time unit later
    task automatic drive(input logic p, input logic q, input logic f);
        push  = p;
        pop   = q;
        flush = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushes(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;

        // Reset held two cycles with push asserted
        #1;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_full",    32'(full),    32'd0);
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        chk("rst_rd_en",   32'(rd_en),   32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);
        chk("rst_err_udf", 32'(err_udf), 32'd0);

        // Four single-word pushes fill one read group
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("p_wr_en",   32'(wr_en),   32'd1);
            chk("p_wr_addr", 32'(wr_addr), 32'(i));
            chk("p_empty",   32'(empty),   32'd1);
            chk("p_rd_en",   32'(rd_en),   32'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        chk("c5_empty",   32'(empty),   32'd0);
        chk("c5_rd_en",   32'(rd_en),   32'd1);
        chk("c5_rd_addr", 32'(rd_addr), 32'd0);
        chk("c5_count",   32'(count),   32'd4);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("c6_rd_addr", 32'(rd_addr), 32'd4);
        chk("c6_count",   32'(count),   32'd0);
        chk("c6_empty",   32'(empty),   32'd1);

        // Fill from a clean start, then overflow
        do_reset();
        pushes(16);
        chk("fill_count",   32'(count),   32'd16);
        chk("fill_full",    32'(full),    32'd1);
        chk("fill_wr_addr", 32'(wr_addr), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        chk("ovf_wr_en", 32'(wr_en), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("ovf_count", 32'(count),   32'd16);
        chk("ovf_err",   32'(err_ovf), 32'd1);

        // Push while full alongside an accepted pop: only the pop lands
        drive(1'b1, 1'b1, 1'b0);
        chk("fb_wr_en", 32'(wr_en), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("fb_count",   32'(count),   32'd12);
        chk("fb_wr_addr", 32'(wr_addr), 32'd0);
        chk("fb_rd_addr", 32'(rd_addr), 32'd4);
        pops(3);
        chk("wrap_rd_addr", 32'(rd_addr), 32'd0);
        chk("wrap_count",   32'(count),   32'd0);
        chk("ovf_sticky",   32'(err_ovf), 32'd1);

        // Simultaneous push and pop from count=8
        pushes(8);
        chk("sim_pre_count",   32'(count),   32'd8);
        chk("sim_pre_wr_addr", 32'(wr_addr), 32'd8);
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("sim_count",   32'(count),   32'd5);
        chk("sim_wr_addr", 32'(wr_addr), 32'd9);
        chk("sim_rd_addr", 32'(rd_addr), 32'd4);
        chk("sim_err_udf", 32'(err_udf), 32'd0);

        // Underflow at count=3
        pops(1);
        pushes(2);
        chk("udf_pre_count", 32'(count), 32'd3);
        drive(1'b0, 1'b1, 1'b0);
        chk("udf_rd_en", 32'(rd_en), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("udf_rd_addr", 32'(rd_addr), 32'd8);
        chk("udf_count",   32'(count),   32'd3);
        chk("udf_err",     32'(err_udf), 32'd1);
        pushes(1);
        chk("udf_empty", 32'(empty), 32'd0);
        chk("udf_count4", 32'(count), 32'd4);

        // Flush at count=10 overrides push and pop, keeps error flags
        pushes(6);
        chk("fl_pre_count", 32'(count), 32'd10);
        drive(1'b1, 1'b1, 1'b1);
        chk("fl_wr_en", 32'(wr_en), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("fl_count",   32'(count),   32'd0);
        chk("fl_wr_addr", 32'(wr_addr), 32'd0);
        chk("fl_rd_addr", 32'(rd_addr), 32'd0);
        chk("fl_err_ovf", 32'(err_ovf), 32'd1);
        chk("fl_err_udf", 32'(err_udf), 32'd1);

        // Mid-operation reset at count=10 clears everything
        pushes(10);
        chk("mr_pre_count", 32'(count), 32'd10);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        chk("mr_wr_en", 32'(wr_en), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("mr_count",   32'(count),   32'd0);
        chk("mr_wr_addr", 32'(wr_addr), 32'd0);
        chk("mr_rd_addr", 32'(rd_addr), 32'd0);
        chk("mr_err_ovf", 32'(err_ovf), 32'd0);
        chk("mr_err_udf", 32'(err_udf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the asymmetric-width FIFO memory in the PE scratch-pad path. It accepts producer push and consumer pop requests and tracks occupancy in memory-word units. It drives the memory's write/read enables and addresses, and reports full/empty, fill level and sticky error flags. The memory writes on the falling clock edge and reads combinationally (first-word fall-through, FWFT); this block owns all pointer state on the rising edge.

## Interface
- `W_DATA_WIDTH`, 16, push width in bits
- `R_DATA_WIDTH`, 64, pop width in bits
- `MEM_WIDTH`, 16, width of one memory word
- `FIFO_DEPTH`, 16, memory words; must equal 2**ADDR_WIDTH
- `ADDR_WIDTH`, 4, address width
- Derived values:
  - WR_STEP = W_DATA_WIDTH/MEM_WIDTH
  - RD_STEP = R_DATA_WIDTH/MEM_WIDTH
  - Both must be powers of two and divide FIFO_DEPTH.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `push`  in  1  producer write request
- `pop`  in  1  consumer read request; consumes the word group currently shown
- `flush`  in  1  synchronous clear of pointers and count
- `wr_en`  out  1  memory write enable
- `wr_addr`  out  ADDR_WIDTH  memory write address
- `rd_en`  out  1  memory read enable (FWFT data valid)
- `rd_addr`  out  ADDR_WIDTH  memory read base address
- `count`  out  ADDR_WIDTH+1  occupied memory words, 0..FIFO_DEPTH
- `full`  out  1  fewer than WR_STEP free words
- `empty`  out  1  fewer than RD_STEP occupied words
- `err_ovf`  out  1  sticky: a push was rejected
- `err_udf`  out  1  sticky: a pop was rejected

## Operation
- **Registered state:**
  - wr_ptr, rd_ptr: ADDR_WIDTH bits each, wrap modulo FIFO_DEPTH.
  - count: ADDR_WIDTH+1 bits.
  - err_ovf, err_udf.
- **Combinational flags:**
  - full = (count > FIFO_DEPTH − WR_STEP).
  - empty = (count < RD_STEP).
- **Request acceptance:**
  - push_ok = push & ~full & rst_n & ~flush.
  - pop_ok = pop & ~empty & rst_n & ~flush.
- **Outputs to memory:**
  - wr_en = push_ok; wr_addr = wr_ptr.
  - rd_en = ~empty; rd_addr = rd_ptr. Data is visible before pop (FWFT).
- **Pointer and count update on rising edge:**
  - wr_ptr += WR_STEP if push_ok.
  - rd_ptr += RD_STEP if pop_ok.
  - count += WR_STEP·push_ok − RD_STEP·pop_ok. Simultaneous accepted push and pop apply both terms in the same cycle.
- **Alignment:** pointers start at 0 and advance by their step, so every multi-word access stays within one aligned block. An access never straddles the end of memory.
- **Errors:**
  - err_ovf is set on push & full & ~flush.
  - err_udf is set on pop & empty & ~flush.
  - Both hold until reset; flush does not clear them.
- **flush:** wr_ptr, rd_ptr and count go to 0 on the next edge. It overrides push and pop, and wr_en is 0 during flush.
- **Reset (rst_n low at edge):** clears all state. wr_en is gated low while rst_n is low, so reset mid-operation never corrupts memory.

## Timing
- **Reset values:** wr_addr=0, rd_addr=0, count=0, empty=1, full=0, wr_en=0, rd_en=0, err_ovf=0, err_udf=0.
- **Push latency:** push accepted in cycle N. Memory is written at the falling edge of N; count updates at the rising edge ending N. The word counts toward empty/rd_en from cycle N+1.
- **Pop latency:** pop accepted in cycle N. rd_addr advances and the next group appears in cycle N+1, if still not empty.
- **Simultaneous push and pop at the flag boundary:** decided on the pre-edge flags. A pop while empty is rejected even if a push is accepted in the same cycle. A push while full is rejected even if a pop is accepted in the same cycle.
- **Wrap-around:** pointers roll from FIFO_DEPTH−step to 0 with no extra cycle.

## Test plan
1. **Reset:** hold rst_n=0 for 2 cycles with push=1 → wr_en=0 throughout. After release: all outputs at reset values.
2. **Push/pop, defaults:**
   - Stimulus: push 0x1111, 0x2222, 0x3333, 0x4444 in cycles 1–4.
   - Cycles 1–4: empty=1, rd_en=0.
   - Cycle 5: empty=0, rd_en=1, rd_addr=0, count=4.
   - Pop in cycle 5 → cycle 6: rd_addr=4, count=0, empty=1.
3. **Fill, overflow, wrap:**
   - 16 pushes → count=16, full=1, wr_addr wrapped to 0.
   - 17th push → wr_en=0, count stays 16, err_ovf=1.
   - err_ovf stays 1 after later pops.
4. **Simultaneous push and pop:** start at count=8, rd_addr=0, wr_addr=8. Push and pop in one cycle → count=5, wr_addr=9, rd_addr=4, no error.
5. **Underflow:**
   - At count=3, pop → ignored; rd_addr unchanged, err_udf=1.
   - Push 1 → next cycle empty=0, count=4.
6. **Flush and mid-operation reset:**
   - At count=10, flush with push=1 and pop=1 → wr_en=0. Next cycle: count=0, both pointers 0, err flags unchanged.
   - Repeat with rst_n=0 instead of flush → err flags also cleared.
